// File: rtl/hash_row_lane_serializer.sv
// Serializes one synchronized hash row into per-lane match requests, lowest lane first.
// Rows without a valid lane are dropped unless they carry the block delimiter.
//
// state  | meaning
// S_IDLE | buffer empty, ready for a row
// S_EMIT | buffer holds a row; emitting request beats or one delimiter-only token
module hash_row_lane_serializer #(
    parameter int ISSUE_W      = 8,
    parameter int ISSUE_W_LOG2 = 3,
    parameter int ADDR_W       = 32,
    parameter int MLEN_W       = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      input_valid,
    input  logic [ADDR_W-1:0]         input_head_addr,
    input  logic [ISSUE_W-1:0]        input_history_valid,
    input  logic [ISSUE_W*ADDR_W-1:0] input_history_addr,
    input  logic [ISSUE_W*MLEN_W-1:0] input_meta_match_len,
    input  logic [ISSUE_W-1:0]        input_meta_match_can_ext,
    input  logic [ISSUE_W*8-1:0]      input_data,
    input  logic                      input_delim,
    output logic                      input_ready,
    output logic                      output_valid,
    output logic                      output_match_valid,
    output logic [ISSUE_W_LOG2-1:0]   output_lane_idx,
    output logic [ADDR_W-1:0]         output_head_addr,
    output logic [ADDR_W-1:0]         output_history_addr,
    output logic [MLEN_W-1:0]         output_meta_match_len,
    output logic                      output_meta_match_can_ext,
    output logic [ISSUE_W*8-1:0]      output_row_data,
    output logic                      output_last,
    output logic                      output_delim,
    input  logic                      output_ready,
    output logic [31:0]               stat_row_cnt,
    output logic [31:0]               stat_req_cnt
);

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [ISSUE_W-1:0]        pending_mask;
    logic [ADDR_W-1:0]         head_addr_r;
    logic [ADDR_W-1:0]         hist_addr_r [ISSUE_W];
    logic [MLEN_W-1:0]         meta_len_r  [ISSUE_W];
    logic [ISSUE_W-1:0]        can_ext_r;
    logic [ISSUE_W*8-1:0]      data_r;
    logic                      delim_r;
    logic [ISSUE_W_LOG2-1:0]   sel;
    logic                      has_req;
    logic                      one_left;
    logic                      row_live;
    logic                      fire_out;
    logic                      accept;

    // Lowest pending lane wins; the descending scan leaves the smallest index in sel.
    always_comb begin
        sel = '0;
        for (int i = ISSUE_W - 1; i >= 0; i--) begin
            if (pending_mask[i]) sel = ISSUE_W_LOG2'(i);
        end
    end

    assign has_req  = |pending_mask;
    assign one_left = (pending_mask & (pending_mask - ISSUE_W'(1))) == '0;
    assign row_live = (|input_history_valid) | input_delim;
    assign fire_out = output_valid & output_ready;
    assign accept   = input_valid & input_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && row_live) state_nxt = S_EMIT;
            end
            S_EMIT: begin
                if (fire_out && output_last) state_nxt = (accept && row_live) ? S_EMIT : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        output_valid              = (state == S_EMIT);
        output_match_valid        = has_req;
        output_last               = one_left;
        output_delim              = delim_r & one_left;
        output_head_addr          = head_addr_r + ADDR_W'(sel);
        output_row_data           = data_r;
        output_lane_idx           = '0;
        output_history_addr       = '0;
        output_meta_match_len     = '0;
        output_meta_match_can_ext = 1'b0;
        if (has_req) begin
            output_lane_idx           = sel;
            output_history_addr       = hist_addr_r[sel];
            output_meta_match_len     = meta_len_r[sel];
            output_meta_match_can_ext = can_ext_r[sel];
        end
        input_ready = (state == S_IDLE) | (output_valid & output_ready & one_left);
    end

    // Payload is only meaningful while output_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            head_addr_r <= input_head_addr;
            can_ext_r   <= input_meta_match_can_ext;
            data_r      <= input_data;
            delim_r     <= input_delim;
            for (int i = 0; i < ISSUE_W; i++) begin
                hist_addr_r[i] <= input_history_addr[i*ADDR_W +: ADDR_W];
                meta_len_r[i]  <= input_meta_match_len[i*MLEN_W +: MLEN_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_mask <= '0;
            stat_row_cnt <= '0;
            stat_req_cnt <= '0;
        end else begin
            if (accept)        pending_mask <= input_history_valid;
            else if (fire_out) pending_mask <= pending_mask & ~(ISSUE_W'(1) << sel);
            if (accept)              stat_row_cnt <= stat_row_cnt + 32'd1;
            if (fire_out && has_req) stat_req_cnt <= stat_req_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_hash_row_lane_serializer.sv
// Bench for hash_row_lane_serializer: directed scenarios plus randomized rows with
// output stalls checked against a queue of beats expanded from each accepted row.
module tb_hash_row_lane_serializer;
    localparam int IW = 8;
    localparam int AW = 32;
    localparam int MW = 5;
    localparam int N_ROWS = 1000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            input_valid = 1'b0;
    logic [AW-1:0]   input_head_addr = '0;
    logic [IW-1:0]   input_history_valid = '0;
    logic [IW*AW-1:0] input_history_addr = '0;
    logic [IW*MW-1:0] input_meta_match_len = '0;
    logic [IW-1:0]   input_meta_match_can_ext = '0;
    logic [IW*8-1:0] input_data = '0;
    logic            input_delim = 1'b0;
    logic            input_ready;
    logic            output_valid;
    logic            output_match_valid;
    logic [2:0]      output_lane_idx;
    logic [AW-1:0]   output_head_addr;
    logic [AW-1:0]   output_history_addr;
    logic [MW-1:0]   output_meta_match_len;
    logic            output_meta_match_can_ext;
    logic [IW*8-1:0] output_row_data;
    logic            output_last;
    logic            output_delim;
    logic            output_ready = 1'b0;
    logic [31:0]     stat_row_cnt;
    logic [31:0]     stat_req_cnt;

    typedef struct packed {
        logic          mv;
        logic [2:0]    lane;
        logic [AW-1:0] head;
        logic [AW-1:0] hist;
        logic [MW-1:0] meta;
        logic          ce;
        logic [IW*8-1:0] data;
        logic          last;
        logic          delim;
    } beat_t;

    int n_tests = 0;
    int n_fail  = 0;
    beat_t exp_q[$];
    int exp_reqs;

    hash_row_lane_serializer dut (
        .clk(clk), .rst_n(rst_n),
        .input_valid(input_valid), .input_head_addr(input_head_addr),
        .input_history_valid(input_history_valid), .input_history_addr(input_history_addr),
        .input_meta_match_len(input_meta_match_len), .input_meta_match_can_ext(input_meta_match_can_ext),
        .input_data(input_data), .input_delim(input_delim), .input_ready(input_ready),
        .output_valid(output_valid), .output_match_valid(output_match_valid),
        .output_lane_idx(output_lane_idx), .output_head_addr(output_head_addr),
        .output_history_addr(output_history_addr), .output_meta_match_len(output_meta_match_len),
        .output_meta_match_can_ext(output_meta_match_can_ext), .output_row_data(output_row_data),
        .output_last(output_last), .output_delim(output_delim), .output_ready(output_ready),
        .stat_row_cnt(stat_row_cnt), .stat_req_cnt(stat_req_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic beat_t obs();
        return {output_match_valid, output_lane_idx, output_head_addr, output_history_addr,
                output_meta_match_len, output_meta_match_can_ext, output_row_data,
                output_last, output_delim};
    endfunction

    // Expand a row into the beats it must produce: one per valid lane in ascending order,
    // or a single delimiter token if no lane is valid and the row ends a block.
    function automatic void push_row(input logic [AW-1:0] head, input logic [IW-1:0] hv,
                                     input logic dl, input logic [IW*AW-1:0] hist,
                                     input logic [IW*MW-1:0] meta, input logic [IW-1:0] ce,
                                     input logic [IW*8-1:0] data);
        int top = -1;
        beat_t b;
        for (int i = 0; i < IW; i++) if (hv[i]) top = i;
        for (int i = 0; i < IW; i++) begin
            if (hv[i]) begin
                b.mv = 1'b1; b.lane = 3'(i); b.head = head + AW'(i);
                b.hist = hist[i*AW +: AW]; b.meta = meta[i*MW +: MW]; b.ce = ce[i];
                b.data = data; b.last = (i == top); b.delim = dl && (i == top);
                exp_q.push_back(b);
                exp_reqs++;
            end
        end
        if (hv == '0 && dl) begin
            b = '{mv: 1'b0, lane: 3'd0, head: head, hist: '0, meta: '0, ce: 1'b0,
                  data: data, last: 1'b1, delim: 1'b1};
            exp_q.push_back(b);
        end
    endfunction

    task automatic set_row(input logic [AW-1:0] head, input logic [IW-1:0] hv, input logic dl);
        input_valid = 1'b1;
        input_head_addr = head;
        input_history_valid = hv;
        input_delim = dl;
        for (int i = 0; i < IW; i++) begin
            input_history_addr[i*AW +: AW] = $urandom;
            input_meta_match_len[i*MW +: MW] = MW'($urandom);
            input_meta_match_can_ext[i] = 1'($urandom_range(0, 1));
        end
        input_data = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; input_valid = 1'b0; output_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_tests++;
        if ({output_valid, input_ready, stat_row_cnt, stat_req_cnt} !== {1'b0, 1'b1, 64'd0}) begin
            n_fail++;
            $display("FAIL reset: valid=%b ready=%b rows=%0d reqs=%0d, want 0 1 0 0",
                     output_valid, input_ready, stat_row_cnt, stat_req_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_row();
        int lanes[3] = '{2, 5, 7};
        logic [IW*AW-1:0] hist;
        do_reset();
        output_ready = 1'b1;
        set_row(32'd100, 8'b1010_0100, 1'b0);
        hist = input_history_addr;
        @(posedge clk); #1;
        input_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if ({output_valid, output_match_valid, output_lane_idx, output_head_addr, output_last,
                 output_delim, output_history_addr} !==
                {1'b1, 1'b1, 3'(lanes[k]), 32'd100 + 32'(lanes[k]), (k == 2), 1'b0,
                 hist[lanes[k]*AW +: AW]}) begin
                n_fail++;
                $display("FAIL single_row beat %0d: v=%b lane=%0d head=%0d last=%b hist=%h, want lane %0d head %0d",
                         k, output_valid, output_lane_idx, output_head_addr, output_last,
                         output_history_addr, lanes[k], 100 + lanes[k]);
            end
        end
        @(negedge clk);
        n_tests++;
        if ({output_valid, stat_req_cnt, stat_row_cnt} !== {1'b0, 32'd3, 32'd1}) begin
            n_fail++;
            $display("FAIL single_row end: valid=%b reqs=%0d rows=%0d, want 0 3 1",
                     output_valid, stat_req_cnt, stat_row_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_drop_row();
        do_reset();
        output_ready = 1'b1;
        set_row(32'd5, 8'h00, 1'b0);
        @(posedge clk); #1;
        input_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_tests++;
            if ({output_valid, input_ready, stat_row_cnt} !== {1'b0, 1'b1, 32'd1}) begin
                n_fail++;
                $display("FAIL drop_row cyc %0d: valid=%b ready=%b rows=%0d, want 0 1 1",
                         k, output_valid, input_ready, stat_row_cnt);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_delim_only();
        do_reset();
        output_ready = 1'b1;
        set_row(32'h40, 8'h00, 1'b1);
        @(posedge clk); #1;
        input_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({output_valid, output_match_valid, output_last, output_delim, output_lane_idx,
             output_history_addr, output_meta_match_len, output_meta_match_can_ext, output_head_addr} !==
            {1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 32'd0, 5'd0, 1'b0, 32'h40}) begin
            n_fail++;
            $display("FAIL delim_only token: v=%b mv=%b last=%b delim=%b lane=%0d hist=%h head=%h",
                     output_valid, output_match_valid, output_last, output_delim,
                     output_lane_idx, output_history_addr, output_head_addr);
        end
        @(negedge clk);
        n_tests++;
        if ({output_valid, stat_req_cnt, stat_row_cnt} !== {1'b0, 32'd0, 32'd1}) begin
            n_fail++;
            $display("FAIL delim_only end: valid=%b reqs=%0d rows=%0d, want 0 0 1",
                     output_valid, stat_req_cnt, stat_row_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        output_ready = 1'b1;
        set_row(32'h200, 8'h03, 1'b0);
        @(posedge clk); #1;
        set_row(32'h300, 8'h80, 1'b0);
        @(negedge clk);
        n_tests++;
        if ({output_valid, output_lane_idx, output_head_addr, output_last, input_ready} !==
            {1'b1, 3'd0, 32'h200, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b beat0: v=%b lane=%0d head=%h last=%b ready=%b",
                     output_valid, output_lane_idx, output_head_addr, output_last, input_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if ({output_valid, output_lane_idx, output_head_addr, output_last, input_ready} !==
            {1'b1, 3'd1, 32'h201, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b beat1: v=%b lane=%0d head=%h last=%b ready=%b",
                     output_valid, output_lane_idx, output_head_addr, output_last, input_ready);
        end
        @(posedge clk); #1;
        input_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({output_valid, output_lane_idx, output_head_addr, output_last} !==
            {1'b1, 3'd7, 32'h307, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b beat2: v=%b lane=%0d head=%h last=%b",
                     output_valid, output_lane_idx, output_head_addr, output_last);
        end
        @(negedge clk);
        n_tests++;
        if ({output_valid, stat_req_cnt, stat_row_cnt} !== {1'b0, 32'd3, 32'd2}) begin
            n_fail++;
            $display("FAIL b2b end: valid=%b reqs=%0d rows=%0d, want 0 3 2",
                     output_valid, stat_req_cnt, stat_row_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        output_ready = 1'b1;
        set_row(32'hFFFF_FFFE, 8'b0000_1010, 1'b0);
        @(posedge clk); #1;
        input_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({output_valid, output_lane_idx, output_head_addr, output_last} !== {1'b1, 3'd1, 32'hFFFF_FFFF, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap beat0: lane=%0d head=%h last=%b, want 1 ffffffff 0",
                     output_lane_idx, output_head_addr, output_last);
        end
        @(negedge clk);
        n_tests++;
        if ({output_valid, output_lane_idx, output_head_addr, output_last} !== {1'b1, 3'd3, 32'h0000_0001, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap beat1: lane=%0d head=%h last=%b, want 3 00000001 1",
                     output_lane_idx, output_head_addr, output_last);
        end
        @(posedge clk); #1;
        set_row(32'h10, 8'hFF, 1'b0);
        @(posedge clk); #1;
        input_valid = 1'b0;
        output_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({output_valid, output_lane_idx} !== {1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL midrow pre-reset: valid=%b lane=%0d, want 1 0", output_valid, output_lane_idx);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if ({output_valid, stat_row_cnt, stat_req_cnt} !== {1'b0, 64'd0}) begin
            n_fail++;
            $display("FAIL midrow reset: valid=%b rows=%0d reqs=%0d, want 0 0 0",
                     output_valid, stat_row_cnt, stat_req_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        output_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({output_valid, input_ready} !== {1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL post-reset: valid=%b ready=%b, want 0 1", output_valid, input_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random_stalls();
        int rows_acc = 0;
        int cyc = 0;
        bit done = 0;
        bit prev_stall = 0;
        beat_t prev_beat;
        beat_t o;
        beat_t e;
        logic [IW-1:0] hv;
        do_reset();
        exp_q.delete();
        exp_reqs = 0;
        while (!done && cyc < 30000) begin
            if (!input_valid && rows_acc < N_ROWS && $urandom_range(0, 3) != 0) begin
                hv = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                set_row($urandom, hv, ($urandom_range(0, 3) == 0));
            end
            output_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            o = obs();
            if (prev_stall) begin
                n_tests++;
                if (!output_valid || o !== prev_beat) begin
                    n_fail++;
                    $display("FAIL stall_stable cyc %0d: valid=%b got %h want %h", cyc, output_valid, o, prev_beat);
                end
            end
            if (output_valid && output_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL random_beat cyc %0d: unexpected beat %h", cyc, o);
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin
                        n_fail++;
                        $display("FAIL random_beat cyc %0d: got %h want %h", cyc, o, e);
                    end
                end
            end
            prev_stall = output_valid && !output_ready;
            prev_beat = o;
            if (input_valid && input_ready) begin
                push_row(input_head_addr, input_history_valid, input_delim, input_history_addr,
                         input_meta_match_len, input_meta_match_can_ext, input_data);
                rows_acc++;
                @(posedge clk); #1;
                input_valid = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            cyc++;
            if (rows_acc == N_ROWS && exp_q.size() == 0) done = 1;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL random_timeout: rows=%0d pending_beats=%0d after %0d cycles", rows_acc, exp_q.size(), cyc);
        end
        output_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({output_valid, stat_row_cnt, stat_req_cnt} !== {1'b0, 32'(N_ROWS), 32'(exp_reqs)}) begin
            n_fail++;
            $display("FAIL random_counters: valid=%b rows=%0d reqs=%0d, want 0 %0d %0d",
                     output_valid, stat_row_cnt, stat_req_cnt, N_ROWS, exp_reqs);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_drop_row();
        test_delim_only();
        test_back_to_back();
        test_wrap_and_reset();
        test_random_stalls();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hash_row_lane_serializer.md
Name: hash_row_lane_serializer

Overview:
- Sits directly downstream of the hash row synchronizer's output stage register.
- Accepts one synchronized hash row per handshake: head address, per-lane history valid/address, meta match length, can-extend flag, row data bytes and delimiter.
- Serializes the valid lanes, lowest index first, into one match request per cycle for the match PE dispatch stage.
- Drops rows with no valid lane; a delimiter is never dropped.

Parameters:
- ISSUE_W, 8, lanes per row (bound to `HASH_ISSUE_WIDTH).
- ISSUE_W_LOG2, 3, lane index width (bound to `HASH_ISSUE_WIDTH_LOG2).
- ADDR_W, 32, address width (bound to `ADDR_WIDTH).
- MLEN_W, 5, meta match length width (bound to `META_MATCH_LEN_WIDTH).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- input_valid  in  1  row valid
- input_head_addr  in  ADDR_W  address of lane 0
- input_history_valid  in  ISSUE_W  per-lane candidate valid
- input_history_addr  in  ISSUE_W*ADDR_W  per-lane candidate address
- input_meta_match_len  in  ISSUE_W*MLEN_W  per-lane meta match length
- input_meta_match_can_ext  in  ISSUE_W  per-lane can-extend flag
- input_data  in  ISSUE_W*8  row bytes
- input_delim  in  1  row is last of block
- input_ready  out  1  row accepted when valid&ready
- output_valid  out  1  request/token valid
- output_match_valid  out  1  1 = match request, 0 = delimiter-only token
- output_lane_idx  out  ISSUE_W_LOG2  lane index of request
- output_head_addr  out  ADDR_W  head_addr + lane_idx, modulo 2^ADDR_W
- output_history_addr  out  ADDR_W  candidate address of lane
- output_meta_match_len  out  MLEN_W  meta length of lane
- output_meta_match_can_ext  out  1  can-extend of lane
- output_row_data  out  ISSUE_W*8  whole row bytes, unchanged
- output_last  out  1  final beat of current row
- output_delim  out  1  input_delim & output_last
- output_ready  in  1  downstream accept
- stat_row_cnt  out  32  rows accepted, wraps
- stat_req_cnt  out  32  match requests emitted, wraps

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=S_IDLE, pending_mask=0, output_valid=0, both stat counters=0.
  - input_ready=1 from the first cycle after reset.
  - Payload registers are not reset; their values are don't-care while output_valid=0.
- States: S_IDLE (buffer empty) and S_EMIT (buffer holds a row).
- S_IDLE: input_ready=1 and output_valid=0. On accept, latch the full row and set pending_mask=input_history_valid; stat_row_cnt+1.
  - mask!=0 -> S_EMIT.
  - mask==0 and delim=1 -> S_EMIT to emit one delimiter-only token.
  - mask==0 and delim=0 -> row dropped; stay S_IDLE. input_ready stays 1, no output beat.
- S_EMIT, request beat:
  - output_valid=1.
  - sel = lowest set bit of pending_mask; lane fields are muxed from the latched row at sel.
  - output_match_valid=1.
  - output_last=1 iff pending_mask has exactly one bit set.
- S_EMIT, delimiter-only token (empty mask):
  - output_match_valid=0, output_last=1, output_delim=1.
  - Lane fields are 0; output_head_addr = latched head_addr.
- On output_valid&output_ready:
  - Clear bit sel.
  - stat_req_cnt+1 only if output_match_valid.
  - If output_last -> S_IDLE.
- Output payload must stay stable while output_valid&!output_ready.
- Back-to-back: input_ready = (state==S_IDLE) | (output_valid & output_ready & output_last).
  - A row accepted in the same cycle as a last-beat handshake is latched directly; the next cycle is S_EMIT or S_IDLE as per the S_IDLE rules.
  - No bubble between rows.
- Latency: first beat valid 1 cycle after row acceptance.
- Throughput: one beat per cycle; a row with k valid lanes occupies k cycles (1 if it is delimiter-only).
- Counters wrap at 2^32. Simultaneous row accept and request handshake update both counters in the same cycle.
- Beats from one row are always emitted before any beat of the next row (order preserved).
- Reset mid-row discards the buffered row; no partial beat follows reset.

Test Plan:
- Single row, head_addr=100, history_valid=8'b1010_0100 -> beats at lanes 2,5,7; head_addr 102,105,107; output_last only on lane 7; stat_req_cnt=3, stat_row_cnt=1.
- Row with history_valid=0, delim=0 -> no output beat, input_ready stays 1, stat_row_cnt=1.
- Row with history_valid=0, delim=1 -> exactly one beat: match_valid=0, last=1, delim=1.
- Back-to-back rows 8'h03 then 8'h80, output_ready held 1 -> beats lanes 0,1,7 on three consecutive cycles; input_ready=1 on the lane-1 cycle.
- Random output_ready stalls (50%) over 1000 random rows vs. scoreboard -> exact beat sequence, payload stable under stall, delim carried only on the final beat of delim rows.
- head_addr=0xFFFF_FFFE with lanes 1 and 3 valid -> output_head_addr 0xFFFF_FFFF then 0x0000_0001; reset asserted mid-row -> output_valid=0 next cycle, counters 0.
